// File: rtl/sat_pkg.sv
// Shared constants and types for the SAT solver's FAT access path.
package sat_pkg;

  localparam int unsigned VAR_NUM     = 8;
  localparam int unsigned VAR_NUM_LOG = 3;

  localparam int unsigned REQ_BT  = 0;
  localparam int unsigned REQ_BCP = 1;
  localparam int unsigned REQ_DEC = 2;

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_t;

  // Round-robin pointer only ever names one of the two fair requesters.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'(REQ_BCP)) ? 2'(REQ_DEC) : 2'(REQ_BCP);
  endfunction

endpackage

// File: rtl/fat_rr_pick.sv
// Combinational picker: backtrack requester wins outright, BCP and decision
// requesters share by a two-way round-robin pointer.
module fat_rr_pick
  import sat_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] rr_ptr,
  output logic [2:0] pick,
  output logic       pick_valid
);

  always_comb begin
    pick = '0;
    if (req[REQ_BT]) begin
      pick[REQ_BT] = 1'b1;
    end else if (req[REQ_BCP] && req[REQ_DEC]) begin
      if (rr_ptr == 2'(REQ_DEC)) pick[REQ_DEC] = 1'b1;
      else                       pick[REQ_BCP] = 1'b1;
    end else if (req[REQ_BCP]) begin
      pick[REQ_BCP] = 1'b1;
    end else if (req[REQ_DEC]) begin
      pick[REQ_DEC] = 1'b1;
    end
  end

  assign pick_valid = |pick;

endmodule

// File: rtl/fat_port_arbiter.sv
// Burst arbiter for the single-port FAT RAM: backtrack, BCP writer and decision
// unit share the port; read data returns tagged with the issuing requester.
module fat_port_arbiter #(
  parameter int unsigned VAR_NUM     = sat_pkg::VAR_NUM,
  parameter int unsigned VAR_NUM_LOG = sat_pkg::VAR_NUM_LOG,
  parameter int unsigned MAX_BURST   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   req,
  input  logic [2:0]                   req_write,
  input  logic [2:0]                   req_last,
  input  logic [3*(VAR_NUM_LOG+1)-1:0] req_addr,
  input  logic [3*VAR_NUM-1:0]         req_wdata,
  output logic [2:0]                   gnt,
  output logic                         fat_en,
  output logic                         fat_write,
  output logic [VAR_NUM_LOG:0]         fat_address,
  output logic [VAR_NUM-1:0]           fat_wdata,
  input  logic [VAR_NUM-1:0]           fat_out,
  output logic                         rd_valid,
  output logic [1:0]                   rd_id,
  output logic [VAR_NUM-1:0]           rd_data,
  output logic                         busy,
  output logic                         err_burst
);

  import sat_pkg::*;

  localparam int unsigned AW = VAR_NUM_LOG + 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_t    state;
  logic [1:0]    owner;
  logic [1:0]    rr_ptr;
  logic [CW-1:0] beat_cnt;

  logic [2:0] pick;
  logic       pick_valid;
  logic [2:0] gnt_c;
  logic [1:0] gnt_idx;
  logic       at_limit;
  logic       burst_end;

  fat_rr_pick u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  // Grant is zero-latency; holding reset low masks it immediately.
  always_comb begin
    gnt_c = '0;
    if (rst) begin
      if (state == IDLE) begin
        if (pick_valid) gnt_c = pick;
      end else begin
        gnt_c[owner] = req[owner];
      end
    end
  end

  always_comb begin
    gnt_idx = 2'(REQ_BT);
    if (gnt_c[REQ_BCP])      gnt_idx = 2'(REQ_BCP);
    else if (gnt_c[REQ_DEC]) gnt_idx = 2'(REQ_DEC);
  end

  always_comb begin
    fat_write   = 1'b0;
    fat_address = '0;
    fat_wdata   = '0;
    if (|gnt_c) begin
      fat_write   = req_write[gnt_idx];
      fat_address = req_addr[gnt_idx*AW +: AW];
      fat_wdata   = req_wdata[gnt_idx*VAR_NUM +: VAR_NUM];
    end
  end

  assign at_limit  = (beat_cnt == CW'(MAX_BURST - 1));
  assign burst_end = req_last[gnt_idx] | at_limit;

  assign gnt     = gnt_c;
  assign fat_en  = |gnt_c;
  assign busy    = rst & ((state == OWN) | (|gnt_c));
  assign rd_data = fat_out;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= 2'(REQ_BCP);
      beat_cnt  <= '0;
      rd_valid  <= 1'b0;
      rd_id     <= '0;
      err_burst <= 1'b0;
    end else begin
      rd_valid <= |(gnt_c & ~req_write);
      rd_id    <= gnt_idx;
      if (|gnt_c) begin
        if (at_limit) err_burst <= 1'b1;
        if (burst_end) begin
          state    <= IDLE;
          owner    <= '0;
          beat_cnt <= '0;
          if (gnt_idx != 2'(REQ_BT)) rr_ptr <= rr_next(rr_ptr);
        end else begin
          state    <= OWN;
          owner    <= gnt_idx;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end else if (state == OWN) begin
        // Owner withdrew its request mid-burst: release without error.
        state    <= IDLE;
        owner    <= '0;
        beat_cnt <= '0;
        if (owner != 2'(REQ_BT)) rr_ptr <= rr_next(rr_ptr);
      end
    end
  end

endmodule

// File: tb/tb_fat_port_arbiter.sv
// Bench for fat_port_arbiter: directed scenarios plus randomized burst traffic,
// scored against a behavioural model through grant/read/status queues.
module tb_fat_port_arbiter;

  localparam int VN = 8;
  localparam int VL = 3;
  localparam int AW = VL + 1;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req, req_write, req_last;
  logic [3*AW-1:0]   req_addr;
  logic [3*VN-1:0]   req_wdata;
  logic [2:0]        gnt;
  logic              fat_en, fat_write;
  logic [AW-1:0]     fat_address;
  logic [VN-1:0]     fat_wdata;
  logic [VN-1:0]     fat_out;
  logic              rd_valid;
  logic [1:0]        rd_id;
  logic [VN-1:0]     rd_data;
  logic              busy, err_burst;

  fat_port_arbiter #(.VAR_NUM(VN), .VAR_NUM_LOG(VL), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .fat_en(fat_en),
    .fat_write(fat_write), .fat_address(fat_address), .fat_wdata(fat_wdata),
    .fat_out(fat_out), .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .busy(busy), .err_burst(err_burst)
  );

  always #5 clk = ~clk;

  // FAT RAM seen by the arbiter: one-cycle read latency.
  logic [VN-1:0] mem [0:VN];
  always @(posedge clk)
    if (fat_en) begin
      if (fat_write) mem[fat_address] <= fat_wdata;
      else           fat_out <= mem[fat_address];
    end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit sb_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual unmatched required matched (cycle %0d)", nm, cyc);
  endtask

  typedef struct { int cyc; logic [2:0] gnt; logic wr; logic [AW-1:0] addr; logic [VN-1:0] data; } g_t;
  typedef struct { int cyc; logic [1:0] id; logic [VN-1:0] data; } r_t;
  typedef struct { int cyc; logic busy; logic err; } s_t;
  g_t gq[$];
  r_t rq[$];
  s_t sq[$];

  // Reference model: owner as an int (-1 = none), beats issued, fair pointer.
  int            m_owner = -1;
  int            m_beats = 0;
  int            m_rr    = 1;
  bit            m_err   = 1'b0;
  int            m_g;
  logic [VN-1:0] m_mem [0:VN];

  task automatic close_burst(input int o);
    m_owner = -1;
    m_beats = 0;
    if (o != 0) m_rr = 3 - m_rr;
  endtask

  task automatic model_step();
    int g;
    g_t ge;
    r_t re;
    s_t se;
    logic [AW-1:0] a;
    logic [VN-1:0] d;
    g = -1;
    if (rst) begin
      if (m_owner < 0) begin
        if (req[0])                g = 0;
        else if (req[1] && req[2]) g = m_rr;
        else if (req[1])           g = 1;
        else if (req[2])           g = 2;
      end else if (req[m_owner]) begin
        g = m_owner;
      end
    end
    se.cyc = cyc; se.busy = rst && (m_owner >= 0 || g >= 0); se.err = m_err;
    sq.push_back(se);
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      d = req_wdata[g*VN +: VN];
      ge.cyc = cyc; ge.gnt = 3'(1 << g); ge.wr = req_write[g]; ge.addr = a; ge.data = d;
      gq.push_back(ge);
      if (req_write[g]) m_mem[a] = d;
      else begin
        re.cyc = cyc + 1; re.id = 2'(g); re.data = m_mem[a];
        rq.push_back(re);
      end
    end
    if (!rst) begin
      m_owner = -1; m_beats = 0; m_rr = 1; m_err = 1'b0;
    end else if (g >= 0) begin
      if (m_beats == MB - 1) m_err = 1'b1;
      if (req_last[g] || m_beats == MB - 1) close_burst(g);
      else begin
        m_owner = g;
        m_beats++;
      end
    end else if (m_owner >= 0) begin
      close_burst(m_owner);
    end
    m_g = g;
  endtask

  // Monitor: consumes expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (sb_on) begin
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        chk("sb_status", {30'b0, busy, err_burst}, {30'b0, sq[0].busy, sq[0].err});
        void'(sq.pop_front());
      end else fail_now("sb_status_missing");

      if (fat_en) begin
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          chk("sb_grant", {16'b0, gnt, fat_write, fat_address, fat_wdata},
              {16'b0, gq[0].gnt, gq[0].wr, gq[0].addr, gq[0].data});
          void'(gq.pop_front());
        end else fail_now("sb_grant_unexpected");
      end else begin
        chk("sb_port_idle", {16'b0, gnt, fat_write, fat_address, fat_wdata}, '0);
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          fail_now("sb_grant_missing");
          void'(gq.pop_front());
        end
      end

      if (rd_valid) begin
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
          chk("sb_read", {22'b0, rd_id, rd_data}, {22'b0, rq[0].id, rq[0].data});
          void'(rq.pop_front());
        end else fail_now("sb_read_unexpected");
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        fail_now("sb_read_missing");
        void'(rq.pop_front());
      end
    end
  end

  logic [AW-1:0] b_addr [3];
  logic [VN-1:0] b_data [3];
  logic          b_wr   [3];
  int            act    [3];
  int            rem    [3];

  task automatic step(input logic r_n, input logic [2:0] rq_v, input logic [2:0] wr, input logic [2:0] lst);
    @(posedge clk);
    #1;
    rst = r_n; req = rq_v; req_write = wr; req_last = lst;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*AW +: AW]  = b_addr[i];
      req_wdata[i*VN +: VN] = b_data[i];
    end
    model_step();
    sb_on = 1'b1;
  endtask

  task automatic dstep(input logic r_n, input logic [2:0] rq_v, input logic [2:0] wr,
                       input logic [2:0] lst, input logic [2:0] exp_gnt, input string nm);
    step(r_n, rq_v, wr, lst);
    @(negedge clk);
    chk(nm, {29'b0, gnt}, {29'b0, exp_gnt});
  endtask

  task automatic new_beat(input int i);
    b_addr[i] = AW'($urandom_range(0, VN));
    b_data[i] = VN'($urandom);
    b_wr[i]   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [2:0] rv, lv, wv;
    logic       rstv;
    for (int i = 0; i <= VN; i++) begin
      mem[i]   = '0;
      m_mem[i] = '0;
    end
    fat_out = '0;
    for (int i = 0; i < 3; i++) begin
      b_addr[i] = '0; b_data[i] = '0; b_wr[i] = 1'b0; act[i] = 0; rem[i] = 0;
    end
    rst = 1'b0; req = 3'b111; req_write = '0; req_last = '0; req_addr = '0; req_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", {29'b0, gnt}, 32'd0);
    chk("reset_fat_en", {31'b0, fat_en}, 32'd0);
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_err_burst", {31'b0, err_burst}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);

    // Priority then round robin.
    dstep(1, 3'b111, 3'b000, 3'b000, 3'b001, "t2_bt_beat1");
    dstep(1, 3'b111, 3'b000, 3'b000, 3'b001, "t2_bt_beat2");
    dstep(1, 3'b111, 3'b000, 3'b001, 3'b001, "t2_bt_beat3");
    dstep(1, 3'b110, 3'b000, 3'b010, 3'b010, "t2_bcp_rr");
    dstep(1, 3'b110, 3'b000, 3'b110, 3'b100, "t2_dec_rr");
    dstep(1, 3'b000, 3'b000, 3'b000, 3'b000, "t2_idle");

    // No pre-emption by the backtrack requester.
    dstep(1, 3'b010, 3'b000, 3'b000, 3'b010, "t3_beat1");
    dstep(1, 3'b011, 3'b000, 3'b000, 3'b010, "t3_beat2");
    dstep(1, 3'b011, 3'b000, 3'b000, 3'b010, "t3_beat3");
    dstep(1, 3'b011, 3'b000, 3'b010, 3'b010, "t3_beat4");
    dstep(1, 3'b001, 3'b000, 3'b001, 3'b001, "t3_bt_after");

    // Read tag returns to requester 2 while requester 0 writes.
    b_addr[0] = 4'd5; b_data[0] = 8'hA5;
    dstep(1, 3'b001, 3'b001, 3'b001, 3'b001, "t4_wr_a5");
    b_addr[2] = 4'd5;
    dstep(1, 3'b100, 3'b000, 3'b100, 3'b100, "t4_rd_dec");
    b_addr[0] = 4'd6; b_data[0] = 8'h3C;
    dstep(1, 3'b001, 3'b001, 3'b001, 3'b001, "t4_wr_next");
    chk("t4_rd_valid", {31'b0, rd_valid}, 32'd1);
    chk("t4_rd_id", {30'b0, rd_id}, 32'd2);
    chk("t4_rd_data", {24'b0, rd_data}, 32'h0000_00A5);
    chk("t4_fat_write", {31'b0, fat_write}, 32'd1);

    // Watchdog cuts an unterminated burst at MAX_BURST beats; sentinel address used.
    b_addr[1] = 4'd8; b_addr[2] = 4'd8;
    chk("t5_err_before", {31'b0, err_burst}, 32'd0);
    for (int i = 0; i < MB; i++) dstep(1, 3'b110, 3'b000, 3'b000, 3'b010, "t5_bcp_beat");
    dstep(1, 3'b110, 3'b000, 3'b100, 3'b100, "t5_dec_c17");
    chk("t5_err_burst", {31'b0, err_burst}, 32'd1);
    chk("t5_sentinel_addr", {28'b0, fat_address}, 32'd8);

    // Reset mid-burst.
    b_addr[0] = 4'd1;
    dstep(1, 3'b101, 3'b001, 3'b000, 3'b001, "t6_bt_beat1");
    dstep(0, 3'b101, 3'b001, 3'b000, 3'b000, "t6_rst_beat2");
    dstep(0, 3'b101, 3'b001, 3'b000, 3'b000, "t6_rst_hold");
    chk("t6_fat_en", {31'b0, fat_en}, 32'd0);
    chk("t6_rd_valid", {31'b0, rd_valid}, 32'd0);
    dstep(1, 3'b100, 3'b000, 3'b100, 3'b100, "t6_dec_first");
    chk("t6_err_cleared", {31'b0, err_burst}, 32'd0);

    // Randomized bursts with occasional drops and resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (act[i] == 0) begin
          if ($urandom_range(0, 3) == 0) begin
            act[i] = 1;
            rem[i] = $urandom_range(1, 20);
            new_beat(i);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          act[i] = 0;
        end
      end
      for (int i = 0; i < 3; i++) begin
        rv[i] = (act[i] != 0);
        lv[i] = (act[i] != 0) && (rem[i] == 1);
        wv[i] = b_wr[i];
      end
      rstv = ($urandom_range(0, 299) != 0);
      step(rstv, rv, wv, lv);
      if (m_g >= 0) begin
        rem[m_g]--;
        if (rem[m_g] == 0) act[m_g] = 0;
        else new_beat(m_g);
      end
    end

    repeat (3) step(1, 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    #1;
    sb_on = 1'b0;
    chk("sb_drain", gq.size() + rq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
